// File: rtl/vga_dst.sv
// VGA display timing generator with a tear-free board snapshot for the renderer.
// Optional macro VGA_DST_DBLBUF_EN: stage board writes and publish them at vblank entry.
module vga_dst #(
  parameter int HACT = 800,
  parameter int HFP  = 56,
  parameter int HSW  = 120,
  parameter int HBP  = 64,
  parameter int VACT = 600,
  parameter int VFP  = 37,
  parameter int VSW  = 6,
  parameter int VBP  = 23
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic [767:0] board_in,
  input  logic         board_wr,
  output logic [10:0]  hcnt,
  output logic [9:0]   vcnt,
  output logic         hen,
  output logic         ven,
  output logic         hs,
  output logic         vs,
  output logic         frame_start,
  output logic [767:0] board_out,
  output logic         upd_ack
);

  localparam int HTOT = HACT + HFP + HSW + HBP;
  localparam int VTOT = VACT + VFP + VSW + VBP;

  localparam logic [10:0] H_LAST   = 11'(HTOT - 1);
  localparam logic [10:0] H_ACT    = 11'(HACT);
  localparam logic [10:0] HS_BEG   = 11'(HACT + HFP);
  localparam logic [10:0] HS_END   = 11'(HACT + HFP + HSW - 1);
  localparam logic [9:0]  V_LAST   = 10'(VTOT - 1);
  localparam logic [9:0]  V_ACT    = 10'(VACT);
  localparam logic [9:0]  VS_BEG   = 10'(VACT + VFP);
  localparam logic [9:0]  VS_END   = 10'(VACT + VFP + VSW - 1);

  logic [10:0] h_nxt_s;
  logic [9:0]  v_nxt_s;
  logic        vblank_entry_s;

  // Next counter position; all decodes are taken from it so they align with the counters.
  always_comb begin
    h_nxt_s = hcnt + 11'd1;
    v_nxt_s = vcnt;
    if (hcnt == H_LAST) begin
      h_nxt_s = 11'd0;
      if (vcnt == V_LAST) begin
        v_nxt_s = 10'd0;
      end else begin
        v_nxt_s = vcnt + 10'd1;
      end
    end else begin
      v_nxt_s = vcnt;
    end
  end

  assign vblank_entry_s = (h_nxt_s == 11'd0) && (v_nxt_s == V_ACT);

  // Position counters; reset parks them on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcnt <= H_LAST;
      vcnt <= V_LAST;
    end else begin
      hcnt <= h_nxt_s;
      vcnt <= v_nxt_s;
    end
  end

  // Registered timing decodes.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hen         <= 1'b0;
      ven         <= 1'b0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hen         <= (h_nxt_s < H_ACT);
      ven         <= (v_nxt_s < V_ACT);
      hs          <= (h_nxt_s >= HS_BEG) && (h_nxt_s <= HS_END);
      vs          <= (v_nxt_s >= VS_BEG) && (v_nxt_s <= VS_END);
      frame_start <= (h_nxt_s == 11'd0) && (v_nxt_s == 10'd0);
    end
  end

`ifdef VGA_DST_DBLBUF_EN
  logic [767:0] staging_r;
  logic         pending_r;

  // Staged board: latest write wins, published only on the first vblank cycle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      staging_r <= 768'd0;
      pending_r <= 1'b0;
      board_out <= 768'd0;
      upd_ack   <= 1'b0;
    end else begin
      if (board_wr) begin
        staging_r <= board_in;
      end else begin
        staging_r <= staging_r;
      end
      if (vblank_entry_s && pending_r) begin
        board_out <= staging_r;
        upd_ack   <= 1'b1;
        // A coincident write refills staging and stays pending for next frame.
        pending_r <= board_wr;
      end else begin
        board_out <= board_out;
        upd_ack   <= 1'b0;
        pending_r <= pending_r | board_wr;
      end
    end
  end
`else
  // Direct board capture on every write.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      board_out <= 768'd0;
      upd_ack   <= 1'b0;
    end else begin
      if (board_wr) begin
        board_out <= board_in;
      end else begin
        board_out <= board_out;
      end
      upd_ack <= board_wr;
    end
  end

  logic unused_vblank_s;
  assign unused_vblank_s = vblank_entry_s;
`endif

endmodule

// File: tb/tb_vga_dst.sv
// Self-checking bench for vga_dst with reduced timing so several frames fit in a short run.
module tb_vga_dst;

  localparam int HACT = 8;
  localparam int HFP  = 2;
  localparam int HSW  = 3;
  localparam int HBP  = 2;
  localparam int VACT = 6;
  localparam int VFP  = 2;
  localparam int VSW  = 1;
  localparam int VBP  = 2;
  localparam int HTOT = HACT + HFP + HSW + HBP;   // 15
  localparam int VTOT = VACT + VFP + VSW + VBP;   // 11
  localparam int FRAME = HTOT * VTOT;             // 165

  logic         pclk = 1'b0;
  logic         rst = 1'b1;
  logic [767:0] board_in = 768'd0;
  logic         board_wr = 1'b0;
  logic [10:0]  hcnt;
  logic [9:0]   vcnt;
  logic         hen, ven, hs, vs, frame_start, upd_ack;
  logic [767:0] board_out;

  int n_chk = 0;
  int n_fail = 0;

  vga_dst #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) dut (
    .pclk(pclk), .rst(rst), .board_in(board_in), .board_wr(board_wr),
    .hcnt(hcnt), .vcnt(vcnt), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
    .frame_start(frame_start), .board_out(board_out), .upd_ack(upd_ack)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [767:0] got, input logic [767:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [767:0] rnd_board();
    logic [767:0] b;
    b = 768'd0;
    for (int i = 0; i < 24; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // ---------------- behavioural model ----------------
  int           t = 0;
  bit           started = 0;
  int           e_h = HTOT - 1, e_v = VTOT - 1;
  bit           e_hen = 0, e_ven = 0, e_hs = 0, e_vs = 0, e_fs = 0, e_ack = 0;
  logic [767:0] e_out = 768'd0;
  logic [767:0] m_stage = 768'd0;
  bit           m_pend = 0;

  always @(posedge pclk) begin
    if (rst) begin
      started = 0; t = 0; m_pend = 0; m_stage = 768'd0;
      e_h = HTOT - 1; e_v = VTOT - 1;
      e_hen = 0; e_ven = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_ack = 0;
      e_out = 768'd0;
    end else begin
      if (started) t = t + 1;
      else begin t = 0; started = 1; end
      e_h   = t % HTOT;
      e_v   = (t / HTOT) % VTOT;
      e_hen = (e_h < HACT);
      e_ven = (e_v < VACT);
      e_hs  = (e_h >= HACT + HFP) && (e_h < HACT + HFP + HSW);
      e_vs  = (e_v >= VACT + VFP) && (e_v < VACT + VFP + VSW);
      e_fs  = (t % FRAME) == 0;
`ifdef VGA_DST_DBLBUF_EN
      if (e_h == 0 && e_v == VACT && m_pend) begin
        e_out = m_stage; e_ack = 1; m_pend = 0;
      end else begin
        e_ack = 0;
      end
      if (board_wr) begin m_stage = board_in; m_pend = 1; end
`else
      e_ack = board_wr;
      if (board_wr) e_out = board_in;
`endif
    end
  end

  // Compare process: every negedge, DUT against model (or reset values while rst is high).
  always @(negedge pclk) begin
    if (rst) begin
      chk("rst_hcnt", 768'(hcnt), 768'(HTOT - 1));
      chk("rst_vcnt", 768'(vcnt), 768'(VTOT - 1));
      chk("rst_flags", 768'({hen, ven, hs, vs, frame_start, upd_ack}), 768'd0);
      chk("rst_board", board_out, 768'd0);
    end else begin
      chk("hcnt", 768'(hcnt), 768'(e_h));
      chk("vcnt", 768'(vcnt), 768'(e_v));
      chk("hen", 768'(hen), 768'(e_hen));
      chk("ven", 768'(ven), 768'(e_ven));
      chk("hs", 768'(hs), 768'(e_hs));
      chk("vs", 768'(vs), 768'(e_vs));
      chk("frame_start", 768'(frame_start), 768'(e_fs));
      chk("upd_ack", 768'(upd_ack), 768'(e_ack));
      chk("board_out", board_out, e_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge pclk); #2;
  endtask

  task automatic wait_pos(input int h, input int v);
    bit found;
    found = 0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step();
      if (int'(hcnt) == h && int'(vcnt) == v) begin found = 1; break; end
    end
    if (!found) begin
      n_chk++; n_fail++;
      $display("FAIL wait_pos timeout h=%0d v=%0d", h, v);
    end
  endtask

  task automatic write(input logic [767:0] d);
    board_in = d; board_wr = 1'b1;
    step();
    board_wr = 1'b0;
  endtask

  initial begin
    logic [767:0] a, b, c, e, d;
    int hen_cnt, hs_cnt, hs_first, ven_cnt, vs_cnt, period;

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("first_hcnt", 768'(hcnt), 768'd0);
    chk("first_vcnt", 768'(vcnt), 768'd0);
    chk("first_fs_hen_ven", 768'({frame_start, hen, ven}), 768'h7);

    // One frame: line and frame shape, then period to next frame_start.
    hen_cnt = 0; hs_cnt = 0; hs_first = -1; ven_cnt = 0; vs_cnt = 0; period = -1;
    for (int i = 0; i <= FRAME + 2; i++) begin
      if (i > 0 && frame_start) begin period = i; break; end
      if (i < HTOT) begin
        hen_cnt += int'(hen);
        if (hs && hs_first < 0) hs_first = int'(hcnt);
        hs_cnt += int'(hs);
      end
      ven_cnt += int'(ven);
      vs_cnt  += int'(vs);
      step();
    end
    chk("line_hen_cycles", 768'(hen_cnt), 768'd8);
    chk("line_hs_cycles", 768'(hs_cnt), 768'd3);
    chk("line_hs_start", 768'(hs_first), 768'd10);
    chk("frame_ven_cycles", 768'(ven_cnt), 768'd90);
    chk("frame_vs_cycles", 768'(vs_cnt), 768'd15);
    chk("frame_period", 768'(period), 768'd165);

    // Two writes in one frame: only the latest is published at vblank entry.
    a = rnd_board(); b = rnd_board();
    wait_pos(3, 1); write(a);
    wait_pos(5, 3); write(b);
    wait_pos(0, VACT);
    chk("vblank_board_b", board_out, b);
`ifdef VGA_DST_DBLBUF_EN
    chk("vblank_ack", 768'(upd_ack), 768'd1);
`else
    chk("vblank_ack", 768'(upd_ack), 768'd0);
`endif

    // Write coinciding with the vblank transfer.
    e = rnd_board(); c = rnd_board();
    wait_pos(2, 2); write(e);
    wait_pos(HTOT - 1, VACT - 1); write(c);
`ifdef VGA_DST_DBLBUF_EN
    chk("coincide_board_e", board_out, e);
`else
    chk("coincide_board_c", board_out, c);
`endif
    wait_pos(0, VACT);
    chk("next_frame_board_c", board_out, c);

    // Random writes, model-checked every cycle.
    for (int i = 0; i < 1500; i++) begin
      board_in = rnd_board();
      board_wr = ($urandom_range(0, 19) == 0);
      step();
    end
    board_wr = 1'b0;

    // Reset mid-frame with an update pending.
    d = rnd_board();
    wait_pos(1, 1); write(d);
    wait_pos(0, 3);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    wait_pos(0, VACT);
    chk("post_rst_board", board_out, 768'd0);
    chk("post_rst_ack", 768'(upd_ack), 768'd0);
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
